// File: rtl/portal_indication_arbiter_pkg.sv
// portal_indication_arbiter_pkg: default sizing and the shared queue entry type
package portal_indication_arbiter_pkg;
  localparam int NUM_CH_DEF = 4;
  localparam int DEPTH_DEF  = 8;
  localparam int DATA_W_DEF = 32;
  localparam int CH_W       = 8;
  typedef struct packed {
    logic [CH_W-1:0]       ch;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;
endpackage

// File: rtl/portal_indication_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick, search starts at ptr_i ascending modulo N
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o
);
  logic [PW-1:0] c;
  // Scan from farthest to nearest so the channel closest to ptr_i is written last and wins
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    c       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = PW'((int'(ptr_i) + k) % N);
      if (elig_i[c]) begin
        grant_o = N'(1) << c;
        idx_o   = c;
      end
    end
  end
endmodule

// File: rtl/portal_indication_arbiter.sv
// portal_indication_arbiter: round-robin merge of indication requesters into one
// shared message queue with head-of-queue interrupt reporting
module portal_indication_arbiter
  import portal_indication_arbiter_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_CH-1:0]          ind_req,
  input  logic [NUM_CH*DATA_W-1:0]   ind_data,
  output logic [NUM_CH-1:0]          ind_grant,
  input  logic                       EN_deq,
  output logic                       RDY_deq,
  output logic                       notEmpty,
  output logic [DATA_W-1:0]          first,
  output logic                       intr_status,
  output logic [31:0]                intr_channel,
  input  logic                       EN_cfg,
  input  logic [NUM_CH-1:0]          cfg_mask,
  input  logic                       cfg_intr_en,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  entry_t            mem_q [DEPTH];
  logic [AW-1:0]     head_q, tail_q;
  logic [OW-1:0]     occ_q, occ_d;
  logic [PW-1:0]     rr_q, rr_d, widx;
  logic [NUM_CH-1:0] mask_q, elig;
  logic              ien_q, full, push, pop;
  assign full = occ_q == OW'(DEPTH);
  // RST gates eligibility so no grant can appear while reset is held
  assign elig = ind_req & mask_q & {NUM_CH{~full & ~RST}};
  rr_arbiter #(.N(NUM_CH), .PW(PW)) u_rr (
    .elig_i (elig),
    .ptr_i  (rr_q),
    .grant_o(ind_grant),
    .idx_o  (widx)
  );
  assign push = |ind_grant;
  assign pop  = EN_deq & notEmpty;
  always_comb begin
    occ_d = occ_q + OW'(push) - OW'(pop);
    rr_d  = !push ? rr_q : (widx == PW'(NUM_CH - 1)) ? '0 : widx + 1'b1;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      occ_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      rr_q   <= '0;
      mask_q <= '1;
      ien_q  <= 1'b0;
    end else begin
      occ_q <= occ_d;
      rr_q  <= rr_d;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop) head_q <= head_q + 1'b1;
      if (EN_cfg) begin
        mask_q <= cfg_mask;
        ien_q  <= cfg_intr_en;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (push) mem_q[tail_q] <= '{ch: CH_W'(widx), data: DATA_W_DEF'(ind_data[widx*DATA_W +: DATA_W])};
  end
  assign notEmpty     = occ_q != '0;
  assign RDY_deq      = notEmpty;
  assign occupancy    = occ_q;
  assign intr_status  = notEmpty & ien_q;
  assign first        = notEmpty ? DATA_W'(mem_q[head_q].data) : '0;
  assign intr_channel = notEmpty ? 32'(mem_q[head_q].ch) : 32'hFFFF_FFFF;
endmodule

// File: tb/tb_portal_indication_arbiter.sv
// tb_portal_indication_arbiter: directed scenarios plus randomized traffic against a queue-based model
module tb_portal_indication_arbiter;
  localparam int N = 4;
  localparam int D = 8;
  logic         CLK = 1'b0;
  logic         RST, EN_deq, EN_cfg, cfg_intr_en;
  logic [3:0]   ind_req, cfg_mask, ind_grant;
  logic [127:0] ind_data;
  logic [31:0]  dat [4];
  logic         RDY_deq, notEmpty, intr_status;
  logic [31:0]  first, intr_channel;
  logic [3:0]   occupancy;

  portal_indication_arbiter dut (
    .CLK(CLK), .RST(RST), .ind_req(ind_req), .ind_data(ind_data), .ind_grant(ind_grant),
    .EN_deq(EN_deq), .RDY_deq(RDY_deq), .notEmpty(notEmpty), .first(first),
    .intr_status(intr_status), .intr_channel(intr_channel), .EN_cfg(EN_cfg),
    .cfg_mask(cfg_mask), .cfg_intr_en(cfg_intr_en), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;
  always_comb ind_data = {dat[3], dat[2], dat[1], dat[0]};

  int          q_ch[$];
  logic [31:0] q_dat[$];
  int          m_rr;
  logic [3:0]  m_mask;
  logic        m_ien;
  int          n_pass = 0, n_tot = 0;
  logic [3:0]  g_obs;
  int          g_exp;

  function automatic int pick();
    if (q_ch.size() == D) return -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_rr + k) % N;
      if (ind_req[c] && m_mask[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] vec(int w);
    return (w < 0) ? 4'b0 : 4'(1 << w);
  endfunction

  task automatic model_reset();
    q_ch.delete();
    q_dat.delete();
    m_rr = 0;
    m_mask = '1;
    m_ien = 1'b0;
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic tick();
    #1;
    g_obs = ind_grant;
    g_exp = pick();
    @(posedge CLK);
    #1;
    if (EN_deq && q_ch.size() > 0) begin
      void'(q_ch.pop_front());
      void'(q_dat.pop_front());
    end
    if (g_exp >= 0) begin
      q_ch.push_back(g_exp);
      q_dat.push_back(dat[g_exp]);
      m_rr = (g_exp + 1) % N;
    end
    if (EN_cfg) begin
      m_mask = cfg_mask;
      m_ien = cfg_intr_en;
    end
    @(negedge CLK);
  endtask

  task automatic hard_reset();
    RST = 1'b1;
    ind_req = '0;
    EN_deq = 1'b0;
    EN_cfg = 1'b0;
    cfg_mask = '0;
    cfg_intr_en = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    EN_deq = 1'b0;
    EN_cfg = 1'b0;
    cfg_mask = '0;
    cfg_intr_en = 1'b0;
    ind_req = '1;
    for (int c = 0; c < N; c++) dat[c] = $urandom;
    @(posedge CLK);
    #1;
    n_tot++; if (ind_grant !== 4'b0) $display("FAIL reset_grant: got %b want 0000", ind_grant); else n_pass++;
    n_tot++; if (occupancy !== 4'd0) $display("FAIL reset_occ: got %0d want 0", occupancy); else n_pass++;
    n_tot++; if (notEmpty !== 1'b0 || RDY_deq !== 1'b0) $display("FAIL reset_ne: got %b/%b want 0/0", notEmpty, RDY_deq); else n_pass++;
    n_tot++; if (first !== 32'h0) $display("FAIL reset_first: got %h want 0", first); else n_pass++;
    n_tot++; if (intr_status !== 1'b0) $display("FAIL reset_intr: got %b want 0", intr_status); else n_pass++;
    n_tot++; if (intr_channel !== 32'hFFFF_FFFF) $display("FAIL reset_chan: got %h want ffffffff", intr_channel); else n_pass++;
    ind_req = '0;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    hard_reset();
    EN_cfg = 1'b1;
    cfg_mask = 4'hF;
    cfg_intr_en = 1'b1;
    tick();
    EN_cfg = 1'b0;
    n_tot++; if (intr_status !== 1'b0) $display("FAIL basic_intr_empty: got %b want 0", intr_status); else n_pass++;
    ind_req = 4'b0100;
    dat[2] = 32'hCAFE0002;
    tick();
    ind_req = '0;
    n_tot++; if (g_obs !== 4'b0100) $display("FAIL basic_grant: got %b want 0100", g_obs); else n_pass++;
    n_tot++; if (notEmpty !== 1'b1) $display("FAIL basic_ne: got %b want 1", notEmpty); else n_pass++;
    n_tot++; if (first !== 32'hCAFE0002) $display("FAIL basic_first: got %h want cafe0002", first); else n_pass++;
    n_tot++; if (intr_channel !== 32'd2) $display("FAIL basic_chan: got %h want 2", intr_channel); else n_pass++;
    n_tot++; if (intr_status !== 1'b1) $display("FAIL basic_intr: got %b want 1", intr_status); else n_pass++;
    EN_deq = 1'b1;
    tick();
    EN_deq = 1'b0;
    n_tot++; if (occupancy !== 4'd0) $display("FAIL basic_drain: got %0d want 0", occupancy); else n_pass++;
  endtask

  task automatic test_order();
    int order[10] = '{0, 1, 2, 3, 0, 1, 2, 3, -1, -1};
    hard_reset();
    for (int c = 0; c < N; c++) dat[c] = $urandom;
    ind_req = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tot++; if (g_obs !== vec(order[i])) $display("FAIL order_%0d: got %b want %b", i, g_obs, vec(order[i])); else n_pass++;
    end
    n_tot++; if (occupancy !== 4'd8) $display("FAIL order_full: got %0d want 8", occupancy); else n_pass++;
  endtask

  task automatic test_full_deq();
    ind_req = 4'b0010;
    EN_deq = 1'b1;
    tick();
    n_tot++; if (g_obs !== 4'b0) $display("FAIL full_deq_grant: got %b want 0000", g_obs); else n_pass++;
    n_tot++; if (occupancy !== 4'd7) $display("FAIL full_deq_occ: got %0d want 7", occupancy); else n_pass++;
    EN_deq = 1'b0;
    tick();
    n_tot++; if (g_obs !== 4'b0010) $display("FAIL full_regrant: got %b want 0010", g_obs); else n_pass++;
    n_tot++; if (occupancy !== 4'd8) $display("FAIL full_refill: got %0d want 8", occupancy); else n_pass++;
    n_tot++; if (intr_channel !== 32'd1) $display("FAIL full_head_chan: got %h want 1", intr_channel); else n_pass++;
    n_tot++; if (first !== q_dat[0]) $display("FAIL full_head_data: got %h want %h", first, q_dat[0]); else n_pass++;
    ind_req = '0;
    EN_deq = 1'b1;
    repeat (8) tick();
    EN_deq = 1'b0;
    n_tot++; if (occupancy !== 4'd0) $display("FAIL full_drain: got %0d want 0", occupancy); else n_pass++;
  endtask

  task automatic test_mask();
    hard_reset();
    EN_cfg = 1'b1;
    cfg_mask = 4'b1010;
    tick();
    EN_cfg = 1'b0;
    ind_req = 4'hF;
    EN_deq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tot++; if (g_obs !== ((i % 2 == 1) ? 4'b1000 : 4'b0010)) $display("FAIL mask_%0d: got %b want %b", i, g_obs, (i % 2 == 1) ? 4'b1000 : 4'b0010); else n_pass++;
    end
    ind_req = '0;
    EN_deq = 1'b0;
    n_tot++; if (intr_status !== 1'b0) $display("FAIL mask_intr_off: got %b want 0", intr_status); else n_pass++;
  endtask

  task automatic test_reset_mid();
    hard_reset();
    dat[0] = $urandom;
    ind_req = 4'b0001;
    repeat (3) tick();
    ind_req = '0;
    n_tot++; if (occupancy !== 4'd3) $display("FAIL mid_occ3: got %0d want 3", occupancy); else n_pass++;
    #2;
    RST = 1'b1;
    #1;
    n_tot++; if (occupancy !== 4'd0) $display("FAIL mid_async_occ: got %0d want 0", occupancy); else n_pass++;
    n_tot++; if (notEmpty !== 1'b0) $display("FAIL mid_async_ne: got %b want 0", notEmpty); else n_pass++;
    n_tot++; if (intr_channel !== 32'hFFFF_FFFF) $display("FAIL mid_async_chan: got %h want ffffffff", intr_channel); else n_pass++;
    RST = 1'b0;
    model_reset();
    @(negedge CLK);
    EN_deq = 1'b1;
    tick();
    EN_deq = 1'b0;
    n_tot++; if (occupancy !== 4'd0 || notEmpty !== 1'b0) $display("FAIL mid_deq_empty: got %0d/%b want 0/0", occupancy, notEmpty); else n_pass++;
    n_tot++; if (first !== 32'h0) $display("FAIL mid_deq_first: got %h want 0", first); else n_pass++;
  endtask

  task automatic test_random();
    hard_reset();
    g_obs = '0;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) begin
        if (!(ind_req[c] && !g_obs[c] && $urandom_range(3) != 0)) begin
          ind_req[c] = 1'($urandom_range(1));
          dat[c] = $urandom;
        end
      end
      EN_deq = (i < 200) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      EN_cfg = ($urandom_range(15) == 0);
      cfg_mask = 4'($urandom);
      cfg_intr_en = 1'($urandom);
      tick();
      n_tot++; if (g_obs !== vec(g_exp)) $display("FAIL rand_grant_%0d: got %b want %b", i, g_obs, vec(g_exp)); else n_pass++;
      n_tot++; if (occupancy !== 4'(q_ch.size())) $display("FAIL rand_occ_%0d: got %0d want %0d", i, occupancy, q_ch.size()); else n_pass++;
      n_tot++; if (notEmpty !== (q_ch.size() > 0) || RDY_deq !== notEmpty) $display("FAIL rand_ne_%0d: got %b/%b want %b", i, notEmpty, RDY_deq, q_ch.size() > 0); else n_pass++;
      n_tot++; if (first !== (q_ch.size() > 0 ? q_dat[0] : 32'h0)) $display("FAIL rand_first_%0d: got %h want %h", i, first, q_ch.size() > 0 ? q_dat[0] : 32'h0); else n_pass++;
      n_tot++; if (intr_channel !== (q_ch.size() > 0 ? 32'(q_ch[0]) : 32'hFFFF_FFFF)) $display("FAIL rand_chan_%0d: got %h want %h", i, intr_channel, q_ch.size() > 0 ? 32'(q_ch[0]) : 32'hFFFF_FFFF); else n_pass++;
      n_tot++; if (intr_status !== (q_ch.size() > 0 && m_ien)) $display("FAIL rand_intr_%0d: got %b want %b", i, intr_status, q_ch.size() > 0 && m_ien); else n_pass++;
    end
    ind_req = '0;
    EN_deq = 1'b0;
    EN_cfg = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    ind_req = '0;
    for (int c = 0; c < N; c++) dat[c] = '0;
    test_reset();
    test_basic();
    test_order();
    test_full_deq();
    test_mask();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
